// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipeline hazard controller slice.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WAIT_CNT_W = 16;
    localparam int PERF_CNT_W = 32;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IMEM_WAIT = 2'd1,
        DMEM_WAIT = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave): hazard sources in, stage enables/flags out.
interface pipe_hazard_ctrl_if;
    import cpu_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_branch_taken;
    logic                  imem_ready;
    logic                  mem_req;
    logic                  dmem_ready;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  id_ex_write;
    logic                  ex_mem_write;
    logic                  mem_wb_write;
    logic                  if_id_flush;
    logic                  id_ex_bubble;
    logic                  mem_timeout;
    logic [PERF_CNT_W-1:0] stall_cnt;
    logic [PERF_CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               ex_branch_taken, imem_ready, mem_req, dmem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_bubble, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               ex_branch_taken, imem_ready, mem_req, dmem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_bubble, mem_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module pipe_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count enabled cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: freezes on data-memory waits, flushes on taken
// branches, stalls on load-use and instruction-fetch misses, and flags memory
// waits that run past WAIT_LIMIT cycles.
// Optional: define PIPE_HAZARD_PERF_EN to build the stall/flush counters;
// without it stall_cnt and flush_cnt are tied to zero.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic               clock,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(WAIT_LIMIT);

    hazard_state_t         state_q;
    hazard_state_t         state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_d;
    logic                  timeout_q;

    logic freeze;
    logic load_use;
    logic pc_we;
    logic if_id_we;
    logic down_we;
    logic flush;
    logic bubble;

    // A pending data access freezes everything; the DMEM_WAIT release cycle
    // (dmem_ready=1) is not a freeze and falls through to normal priority.
    assign freeze = !hz.dmem_ready && ((state_q == DMEM_WAIT) || hz.mem_req);

    // x0 never carries a real dependency, so ex_rd==0 cannot cause a stall.
    assign load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    // Stage enables by priority: reset, freeze, branch, load-use/fetch miss.
    always_comb begin
        pc_we    = 1'b1;
        if_id_we = 1'b1;
        down_we  = 1'b1;
        flush    = 1'b0;
        bubble   = 1'b0;
        if (!reset) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            down_we  = 1'b0;
            flush    = 1'b1;
            bubble   = 1'b1;
        end else if (freeze) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            down_we  = 1'b0;
        end else if (hz.ex_branch_taken) begin
            flush    = 1'b1;
            bubble   = 1'b1;
        end else if (load_use || !hz.imem_ready) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            bubble   = 1'b1;
        end
    end

    assign hz.pc_write     = pc_we;
    assign hz.if_id_write  = if_id_we;
    assign hz.id_ex_write  = down_we;
    assign hz.ex_mem_write = down_we;
    assign hz.mem_wb_write = down_we;
    assign hz.if_id_flush  = flush;
    assign hz.id_ex_bubble = bubble;
    assign hz.mem_timeout  = timeout_q;

    // Next-state selection; a taken branch keeps IMEM_WAIT until the fetch lands.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (hz.mem_req && !hz.dmem_ready) begin
                    state_d = DMEM_WAIT;
                end else if (!hz.imem_ready && !hz.ex_branch_taken) begin
                    state_d = IMEM_WAIT;
                end
            end
            IMEM_WAIT: begin
                if (freeze) begin
                    state_d = DMEM_WAIT;
                end else if (hz.imem_ready) begin
                    state_d = RUN;
                end
            end
            DMEM_WAIT: begin
                if (hz.dmem_ready) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Wait counter counts cycles spent in a wait state and clears on return to RUN.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d == RUN) begin
            wait_cnt_d = '0;
        end else if ((state_q != RUN) && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (wait_cnt_d >= LIMIT) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    pipe_sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (!pc_we),
        .count (hz.stall_cnt)
    );

    pipe_sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush),
        .count (hz.flush_cnt)
    );
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (WAIT_LIMIT=4). Honors
// PIPE_HAZARD_PERF_EN when it is defined for the build.
module tb_pipe_hazard_ctrl;

    localparam int LIMIT = 4;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       ir;
        logic       mq;
        logic       dr;
    } stim_t;

    // Control vector order: pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble
    localparam logic [6:0] V_RESET  = 7'b0000011;
    localparam logic [6:0] V_FREEZE = 7'b0000000;
    localparam logic [6:0] V_BRANCH = 7'b1111111;
    localparam logic [6:0] V_STALL  = 7'b0011101;
    localparam logic [6:0] V_RUN    = 7'b1111100;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = running, 1 = waiting on fetch, 2 = waiting on data
    int          m_mode    = 0;
    int          m_waited  = 0;
    bit          m_timeout = 1'b0;
    int unsigned m_stall   = 0;
    int unsigned m_flush   = 0;

    pipe_hazard_ctrl_if hz_if ();

    pipe_hazard_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz_if.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] dut_ctrl();
        return {hz_if.pc_write, hz_if.if_id_write, hz_if.id_ex_write,
                hz_if.ex_mem_write, hz_if.mem_wb_write,
                hz_if.if_id_flush, hz_if.id_ex_bubble};
    endfunction

    function automatic stim_t idle();
        stim_t s = '0;
        s.ir = 1'b1;
        s.dr = 1'b1;
        return s;
    endfunction

    function automatic bit data_blocked(int mode, stim_t s);
        if (mode == 2) return !s.dr;
        return s.mq && !s.dr;
    endfunction

    function automatic logic [6:0] model_ctrl(int mode, stim_t s);
        bit dep;
        dep = s.mr && (s.rd != 0) &&
              ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        if (data_blocked(mode, s)) return V_FREEZE;
        if (s.br)                  return V_BRANCH;
        if (dep || !s.ir)          return V_STALL;
        return V_RUN;
    endfunction

    function automatic int model_next(int mode, stim_t s);
        case (mode)
            0: if (s.mq && !s.dr) return 2;
               else if (!s.ir && !s.br) return 1;
               else return 0;
            1: if (data_blocked(mode, s)) return 2;
               else if (s.ir) return 0;
               else return 1;
            default: return s.dr ? 0 : 2;
        endcase
    endfunction

    function automatic logic [31:0] exp_stall();
`ifdef PIPE_HAZARD_PERF_EN
        return m_stall;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_flush();
`ifdef PIPE_HAZARD_PERF_EN
        return m_flush;
`else
        return 32'd0;
`endif
    endfunction

    task automatic apply(input stim_t s);
        hz_if.id_rs1          = s.rs1;
        hz_if.id_rs2          = s.rs2;
        hz_if.id_use_rs1      = s.u1;
        hz_if.id_use_rs2      = s.u2;
        hz_if.ex_mem_read     = s.mr;
        hz_if.ex_rd           = s.rd;
        hz_if.ex_branch_taken = s.br;
        hz_if.imem_ready      = s.ir;
        hz_if.mem_req         = s.mq;
        hz_if.dmem_ready      = s.dr;
    endtask

    // One clocked cycle: drive, compare mid-cycle, then advance the model at the edge.
    task automatic cycle(input string tag, input stim_t s);
        logic [6:0] exp_v;
        int nxt;
        apply(s);
        #3;
        exp_v = model_ctrl(m_mode, s);
        check({tag, "_ctrl"}, 32'(dut_ctrl()), 32'(exp_v));
        check({tag, "_timeout"}, 32'(hz_if.mem_timeout), 32'(m_timeout));
        check({tag, "_stall_cnt"}, hz_if.stall_cnt, exp_stall());
        check({tag, "_flush_cnt"}, hz_if.flush_cnt, exp_flush());
        @(posedge clock);
        if (!exp_v[6]) m_stall++;
        if (exp_v[1])  m_flush++;
        nxt = model_next(m_mode, s);
        if (nxt == 0) m_waited = 0;
        else if (m_mode != 0 && m_waited < 65535) m_waited++;
        if (m_waited >= LIMIT) m_timeout = 1'b1;
        m_mode = nxt;
        #1;
    endtask

    // Async reset pulse started mid-cycle; outputs must react with no clock edge.
    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_rst_ctrl"}, 32'(dut_ctrl()), 32'(V_RESET));
        check({tag, "_rst_timeout"}, 32'(hz_if.mem_timeout), 32'd0);
        check({tag, "_rst_stall"}, hz_if.stall_cnt, 32'd0);
        check({tag, "_rst_flush"}, hz_if.flush_cnt, 32'd0);
        m_mode = 0; m_waited = 0; m_timeout = 1'b0; m_stall = 0; m_flush = 0;
        apply(idle());
        @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        stim_t s;

        apply(idle());
        #1;
        check("por_ctrl", 32'(dut_ctrl()), 32'(V_RESET));
        check("por_timeout", 32'(hz_if.mem_timeout), 32'd0);
        check("por_stall", hz_if.stall_cnt, 32'd0);
        check("por_flush", hz_if.flush_cnt, 32'd0);
        @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;

        // Two load-use stalls and one branch, separated by idle cycles
        s = idle(); s.mr = 1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1;
        cycle("lu1", s);
        cycle("lu1_after", idle());
        s = idle(); s.mr = 1; s.rd = 5'd9; s.rs2 = 5'd9; s.u2 = 1;
        cycle("lu2", s);
        cycle("lu2_after", idle());
        s = idle(); s.br = 1;
        cycle("br1", s);
        cycle("br1_after", idle());
`ifdef PIPE_HAZARD_PERF_EN
        check("perf_stall_total", hz_if.stall_cnt, 32'd2);
        check("perf_flush_total", hz_if.flush_cnt, 32'd1);
`else
        check("perf_stall_total", hz_if.stall_cnt, 32'd0);
        check("perf_flush_total", hz_if.flush_cnt, 32'd0);
`endif

        // Load from x0 never stalls; unused source never stalls
        s = idle(); s.mr = 1; s.rd = 5'd0; s.rs1 = 5'd0; s.u1 = 1;
        cycle("lu_x0", s);
        s = idle(); s.mr = 1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 0;
        cycle("lu_unused", s);

        // Data-memory wait of three cycles then release
        s = idle(); s.mq = 1; s.dr = 0;
        for (int i = 0; i < 3; i++) cycle("dwait", s);
        s.dr = 1;
        cycle("drel", s);
        cycle("drel_after", idle());

        // Branch held through a data wait is flushed only after release
        s = idle(); s.mq = 1; s.dr = 0; s.br = 1;
        for (int i = 0; i < 2; i++) cycle("dwait_br", s);
        s.dr = 1;
        cycle("drel_br", s);
        s.mq = 0;
        cycle("br_after_rel", s);
        cycle("br_done", idle());

        // Fetch wait of six cycles trips the timeout, which then sticks
        s = idle(); s.ir = 0;
        for (int i = 0; i < 6; i++) cycle("iwait", s);
        for (int i = 0; i < 3; i++) cycle("iwait_after", idle());

        // Branch while fetch is waiting: flush but keep waiting
        s = idle(); s.ir = 0;
        cycle("iwait2", s);
        s.br = 1;
        cycle("iwait_br", s);
        s.br = 0;
        cycle("iwait_br_hold", s);
        cycle("iwait_rel", idle());

        // Reset in the middle of a data wait restarts in RUN
        s = idle(); s.mq = 1; s.dr = 0;
        cycle("dwait_pre_rst", s);
        cycle("dwait_pre_rst", s);
        pulse_reset("mid");
        cycle("post_rst", idle());

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.u1  = 1'($urandom_range(0, 1));
            s.u2  = 1'($urandom_range(0, 1));
            s.mr  = ($urandom_range(0, 2) == 0);
            s.rd  = 5'($urandom_range(0, 3));
            s.br  = ($urandom_range(0, 5) == 0);
            s.ir  = ($urandom_range(0, 4) != 0);
            s.mq  = ($urandom_range(0, 3) == 0);
            s.dr  = ($urandom_range(0, 2) != 0);
            cycle("rnd", s);
            if (n == 200) pulse_reset("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
